// File: rtl/drf_pkg.sv
// Shared definitions for the DRF control sequencer: opcodes, FSM states,
// instruction classes, flag bit positions and the jump-condition helper.
package drf_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOADIR = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    // Decoded instruction classes
    typedef enum logic [3:0] {
        CLS_ALU     = 4'd0,
        CLS_CMP     = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_SETBANK = 4'd4,
        CLS_NOP     = 4'd5,
        CLS_JUMP    = 4'd6,
        CLS_HALT    = 4'd7,
        CLS_ILLEGAL = 4'd8
    } instr_class_e;

    // Which latched flag a jump tests
    typedef enum logic [1:0] {
        JCOND_ALWAYS = 2'd0,
        JCOND_Z      = 2'd1,
        JCOND_C      = 2'd2,
        JCOND_N      = 2'd3
    } jump_cond_e;

    // Opcode field IR[15:11]
    localparam logic [1:0] OPC_ALU_PREFIX = 2'b00;
    localparam logic [4:0] OPC_LOAD       = 5'b01000;
    localparam logic [4:0] OPC_STORE      = 5'b01001;
    localparam logic [4:0] OPC_SETBANK    = 5'b01010;
    localparam logic [4:0] OPC_NOP        = 5'b01011;
    localparam logic [4:0] OPC_JMP        = 5'b10000;
    localparam logic [4:0] OPC_JZ         = 5'b10001;
    localparam logic [4:0] OPC_JC         = 5'b10010;
    localparam logic [4:0] OPC_JN         = 5'b10011;
    localparam logic [4:0] OPC_HALT       = 5'b11111;

    // ALU code that only updates flags
    localparam logic [2:0] ALU_OP_CMP = 3'b111;

    // Flag bit positions in in_alu_flags and the latched flag register
    localparam int unsigned FLAG_Z = 0;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_V = 3;

    // Evaluate a jump condition against the latched flags
    function automatic logic jump_taken(input logic [3:0] flags, input jump_cond_e cond);
        logic taken;
        case (cond)
            JCOND_ALWAYS: taken = 1'b1;
            JCOND_Z:      taken = flags[FLAG_Z];
            JCOND_C:      taken = flags[FLAG_C];
            JCOND_N:      taken = flags[FLAG_N];
            default:      taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/drf_decoder.sv
// Combinational opcode decoder: instruction class plus jump condition.
module drf_decoder
    import drf_pkg::*;
(
    input  logic [4:0]   opcode,
    output instr_class_e instr_class,
    output jump_cond_e   jump_cond
);

    // Classify the opcode; anything not listed is illegal
    always_comb begin
        instr_class = CLS_ILLEGAL;
        jump_cond   = JCOND_ALWAYS;
        if (opcode[4:3] == OPC_ALU_PREFIX) begin
            if (opcode[2:0] == ALU_OP_CMP) begin
                instr_class = CLS_CMP;
            end else begin
                instr_class = CLS_ALU;
            end
        end else begin
            case (opcode)
                OPC_LOAD:    instr_class = CLS_LOAD;
                OPC_STORE:   instr_class = CLS_STORE;
                OPC_SETBANK: instr_class = CLS_SETBANK;
                OPC_NOP:     instr_class = CLS_NOP;
                OPC_JMP:     begin instr_class = CLS_JUMP; jump_cond = JCOND_ALWAYS; end
                OPC_JZ:      begin instr_class = CLS_JUMP; jump_cond = JCOND_Z;      end
                OPC_JC:      begin instr_class = CLS_JUMP; jump_cond = JCOND_C;      end
                OPC_JN:      begin instr_class = CLS_JUMP; jump_cond = JCOND_N;      end
                OPC_HALT:    instr_class = CLS_HALT;
                default:     instr_class = CLS_ILLEGAL;
            endcase
        end
    end

endmodule

// File: rtl/drf_sequencer.sv
// DRF control sequencer: fetch/decode/execute FSM driving datapath strobes.
// Strobes are decoded from the current state and in_ir so that EXEC/MEM see
// the freshly loaded IR; they all fall to 0 as soon as rst forces IDLE.
module drf_sequencer
    import drf_pkg::*;
#(
    parameter bit AUTO_RUN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_run,
    input  logic [15:0] in_ir,
    input  logic [3:0]  in_alu_flags,
    output logic [2:0]  out_alu_op,
    output logic        out_alu_enable_out,
    output logic        out_pc_load,
    output logic        out_pc_inc,
    output logic        out_ir_load,
    output logic        out_ir_enable_read,
    output logic        out_mbs_wr_enable,
    output logic        out_mar_load,
    output logic        out_data_memory_read_enable,
    output logic        out_data_memory_wr_enable,
    output logic        out_reg_read_en,
    output logic        out_reg_write_en,
    output logic [2:0]  out_rx_selector,
    output logic [2:0]  out_ry_selector,
    output logic        out_halted,
    output logic        out_illegal
);

    state_e       state_q, state_d;
    logic [3:0]   flags_q, flags_d;
    logic         illegal_q, illegal_d;
    instr_class_e instr_class_s;
    jump_cond_e   jump_cond_s;

    logic alu_enable_out_s, pc_load_s, pc_inc_s, ir_load_s, ir_enable_read_s;
    logic mbs_wr_enable_s, mar_load_s, dm_read_enable_s, dm_wr_enable_s;
    logic reg_read_en_s, reg_write_en_s;

    // IR[4:0] and the overflow flag are consumed only by the datapath
    logic unused_bits_s;
    assign unused_bits_s = ^{in_ir[4:0], flags_q[FLAG_V]};

    drf_decoder u_decoder (
        .opcode      (in_ir[15:11]),
        .instr_class (instr_class_s),
        .jump_cond   (jump_cond_s)
    );

    // State, latched ALU flags and sticky illegal flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            flags_q   <= 4'b0000;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and strobe decode; everything defaults to idle/hold
    always_comb begin
        state_d          = state_q;
        flags_d          = flags_q;
        illegal_d        = illegal_q;
        alu_enable_out_s = 1'b0;
        pc_load_s        = 1'b0;
        pc_inc_s         = 1'b0;
        ir_load_s        = 1'b0;
        ir_enable_read_s = 1'b0;
        mbs_wr_enable_s  = 1'b0;
        mar_load_s       = 1'b0;
        dm_read_enable_s = 1'b0;
        dm_wr_enable_s   = 1'b0;
        reg_read_en_s    = 1'b0;
        reg_write_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_run || AUTO_RUN) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                state_d = ST_LOADIR;
            end
            ST_LOADIR: begin
                ir_load_s = 1'b1;
                pc_inc_s  = 1'b1;
                state_d   = ST_EXEC;
            end
            ST_EXEC: begin
                case (instr_class_s)
                    CLS_ALU: begin
                        alu_enable_out_s = 1'b1;
                        reg_write_en_s   = 1'b1;
                        flags_d          = in_alu_flags;
                        state_d          = ST_FETCH;
                    end
                    CLS_CMP: begin
                        alu_enable_out_s = 1'b1;
                        flags_d          = in_alu_flags;
                        state_d          = ST_FETCH;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        ir_enable_read_s = 1'b1;
                        mar_load_s       = 1'b1;
                        state_d          = ST_MEM;
                    end
                    CLS_SETBANK: begin
                        mbs_wr_enable_s = 1'b1;
                        state_d         = ST_FETCH;
                    end
                    CLS_NOP: begin
                        state_d = ST_FETCH;
                    end
                    CLS_JUMP: begin
                        pc_load_s = jump_taken(flags_q, jump_cond_s);
                        state_d   = ST_FETCH;
                    end
                    CLS_HALT: begin
                        state_d = ST_HALT;
                    end
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                endcase
            end
            ST_MEM: begin
                if (instr_class_s == CLS_LOAD) begin
                    dm_read_enable_s = 1'b1;
                    reg_write_en_s   = 1'b1;
                end else if (instr_class_s == CLS_STORE) begin
                    reg_read_en_s  = 1'b1;
                    dm_wr_enable_s = 1'b1;
                end else begin
                    dm_read_enable_s = 1'b0;
                end
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_alu_op                  = in_ir[13:11];
    assign out_rx_selector             = in_ir[10:8];
    assign out_ry_selector             = in_ir[7:5];
    assign out_alu_enable_out          = alu_enable_out_s;
    assign out_pc_load                 = pc_load_s;
    assign out_pc_inc                  = pc_inc_s;
    assign out_ir_load                 = ir_load_s;
    assign out_ir_enable_read          = ir_enable_read_s;
    assign out_mbs_wr_enable           = mbs_wr_enable_s;
    assign out_mar_load                = mar_load_s;
    assign out_data_memory_read_enable = dm_read_enable_s;
    assign out_data_memory_wr_enable   = dm_wr_enable_s;
    assign out_reg_read_en             = reg_read_en_s;
    assign out_reg_write_en            = reg_write_en_s;
    assign out_halted                  = (state_q == ST_HALT);
    assign out_illegal                 = illegal_q;

endmodule

// File: tb/tb_drf_sequencer.sv
// Self-checking bench for drf_sequencer: an instruction-level model queues the
// expected per-cycle outputs; one negedge process compares them to the DUT.
module tb_drf_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_run;
    logic [15:0] in_ir;
    logic [3:0]  in_alu_flags;
    logic [2:0]  out_alu_op, out_rx_selector, out_ry_selector;
    logic        out_alu_enable_out, out_pc_load, out_pc_inc, out_ir_load;
    logic        out_ir_enable_read, out_mbs_wr_enable, out_mar_load;
    logic        out_data_memory_read_enable, out_data_memory_wr_enable;
    logic        out_reg_read_en, out_reg_write_en, out_halted, out_illegal;

    drf_sequencer #(.AUTO_RUN(1'b0)) dut (
        .clk(clk), .rst(rst), .in_run(in_run), .in_ir(in_ir), .in_alu_flags(in_alu_flags),
        .out_alu_op(out_alu_op), .out_alu_enable_out(out_alu_enable_out),
        .out_pc_load(out_pc_load), .out_pc_inc(out_pc_inc), .out_ir_load(out_ir_load),
        .out_ir_enable_read(out_ir_enable_read), .out_mbs_wr_enable(out_mbs_wr_enable),
        .out_mar_load(out_mar_load),
        .out_data_memory_read_enable(out_data_memory_read_enable),
        .out_data_memory_wr_enable(out_data_memory_wr_enable),
        .out_reg_read_en(out_reg_read_en), .out_reg_write_en(out_reg_write_en),
        .out_rx_selector(out_rx_selector), .out_ry_selector(out_ry_selector),
        .out_halted(out_halted), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] ir;
        logic alu_en, pc_load, pc_inc, ir_load, ir_rd, mbs, mar;
        logic dm_rd, dm_wr, reg_rd, reg_wr, halted, illegal;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    // Architectural model state
    logic [3:0] model_flags;
    logic       model_halted, model_illegal;

    // Opcode bits shown on the IR while fetching: HALT, so early decode would show
    localparam logic [15:0] FETCH_JUNK = 16'hF800;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    function automatic logic [12:0] dut_strobes();
        return {out_alu_enable_out, out_pc_load, out_pc_inc, out_ir_load, out_ir_enable_read,
                out_mbs_wr_enable, out_mar_load, out_data_memory_read_enable,
                out_data_memory_wr_enable, out_reg_read_en, out_reg_write_en,
                out_halted, out_illegal};
    endfunction

    task automatic push(input logic [15:0] ir, input exp_t e, input string tag);
        e.ir      = ir;
        e.halted  = model_halted;
        e.illegal = model_illegal;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // One clock cycle: drive inputs just after the edge and queue its expectation
    task automatic step(input logic [15:0] ir, input logic [3:0] fl, input exp_t e, input string tag);
        @(posedge clk);
        #1;
        in_ir        = ir;
        in_alu_flags = fl;
        push(ir, e, tag);
    endtask

    task automatic idle_cycles(input int n, input logic [15:0] ir, input string tag);
        for (int i = 0; i < n; i++) step(ir, 4'hF, '0, tag);
    endtask

    // Instruction-level model: expected cycles of one instruction
    task automatic exec_instr(input logic [15:0] ir, input logic [3:0] live_flags, input string nm);
        exp_t       e;
        logic [4:0] op;
        logic       is_alu, is_cmp, is_mem, known;
        op     = ir[15:11];
        is_alu = (op[4:3] == 2'b00);
        is_cmp = is_alu && (op[2:0] == 3'b111);
        is_mem = (op == 5'b01000) || (op == 5'b01001);
        known  = is_alu || is_mem || (op == 5'b01010) || (op == 5'b01011) ||
                 (op >= 5'b10000 && op <= 5'b10011) || (op == 5'b11111);
        e = '0;
        step(FETCH_JUNK, live_flags, e, {nm, " fetch"});
        e = '0; e.ir_load = 1'b1; e.pc_inc = 1'b1;
        step(FETCH_JUNK, live_flags, e, {nm, " loadir"});
        e = '0;
        if (is_alu) begin
            e.alu_en = 1'b1;
            e.reg_wr = !is_cmp;
        end else if (is_mem) begin
            e.ir_rd = 1'b1;
            e.mar   = 1'b1;
        end else if (op == 5'b01010) begin
            e.mbs = 1'b1;
        end else if (op == 5'b10000) begin
            e.pc_load = 1'b1;
        end else if (op == 5'b10001) begin
            e.pc_load = model_flags[0];
        end else if (op == 5'b10010) begin
            e.pc_load = model_flags[1];
        end else if (op == 5'b10011) begin
            e.pc_load = model_flags[2];
        end else begin
            e.pc_load = 1'b0;
        end
        step(ir, live_flags, e, {nm, " exec"});
        if (is_alu) model_flags = live_flags;
        if (!known) model_illegal = 1'b1;
        if (!known || op == 5'b11111) model_halted = 1'b1;
        if (is_mem) begin
            e = '0;
            if (op == 5'b01000) begin e.dm_rd = 1'b1; e.reg_wr = 1'b1; end
            else begin e.reg_rd = 1'b1; e.dm_wr = 1'b1; end
            step(ir, ~live_flags, e, {nm, " mem"});
        end
    endtask

    task automatic model_reset();
        model_flags   = 4'b0000;
        model_halted  = 1'b0;
        model_illegal = 1'b0;
    endtask

    // Compare process: every queued cycle is checked against the DUT
    always @(negedge clk) begin
        exp_t  e;
        string t;
        logic  excl_ok;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check({t, " strobes"}, 32'(dut_strobes()),
                  32'({e.alu_en, e.pc_load, e.pc_inc, e.ir_load, e.ir_rd, e.mbs, e.mar,
                       e.dm_rd, e.dm_wr, e.reg_rd, e.reg_wr, e.halted, e.illegal}));
            check({t, " selectors"}, 32'({out_alu_op, out_rx_selector, out_ry_selector}),
                  32'({e.ir[13:11], e.ir[10:8], e.ir[7:5]}));
            excl_ok = ($countones({out_alu_enable_out, out_ir_enable_read,
                                   out_data_memory_read_enable, out_reg_read_en}) <= 1) &&
                      !(out_pc_load && out_pc_inc) &&
                      !(out_data_memory_read_enable && out_data_memory_wr_enable);
            check({t, " exclusive"}, 32'(excl_ok), 32'd1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_run = 1'b0; in_ir = 16'h0000; in_alu_flags = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset strobes", 32'(dut_strobes()), 32'd0);

        // Start from IDLE with in_run
        @(posedge clk); #1;
        rst = 1'b0; in_run = 1'b1;
        push(in_ir, '0, "idle");

        exec_instr(16'h0120, 4'h0, "add");
        @(negedge clk);
        check("add alu_enable_out", 32'(out_alu_enable_out), 32'd1);
        check("add reg_write_en", 32'(out_reg_write_en), 32'd1);
        check("add alu_op", 32'(out_alu_op), 32'd0);
        check("add rx_selector", 32'(out_rx_selector), 32'd1);

        exec_instr(16'h3800, 4'b0001, "cmp_z");
        exec_instr(16'h8855, 4'b0000, "jz_taken");
        @(negedge clk);
        check("jz taken pc_load", 32'(out_pc_load), 32'd1);
        exec_instr(16'h3800, 4'b0000, "cmp_0");
        exec_instr(16'h8855, 4'b0001, "jz_not");
        @(negedge clk);
        check("jz not-taken pc_load", 32'(out_pc_load), 32'd0);
        exec_instr(16'h0120, 4'b0010, "add_c");
        exec_instr(16'h9033, 4'b0000, "jc_taken");
        @(negedge clk);
        check("jc taken pc_load", 32'(out_pc_load), 32'd1);
        exec_instr(16'h9855, 4'b0100, "jn_not");

        exec_instr(16'h4312, 4'h0, "load");
        @(negedge clk);
        check("load mem read", 32'(out_data_memory_read_enable), 32'd1);
        exec_instr(16'h4B12, 4'h0, "store");
        @(negedge clk);
        check("store mem write", 32'(out_data_memory_wr_enable), 32'd1);
        exec_instr(16'h5003, 4'h0, "setbank");
        exec_instr(16'h5800, 4'h0, "nop");
        exec_instr(16'h8123, 4'h0, "jmp");

        // Illegal opcode halts and sticks
        exec_instr(16'hF000, 4'h0, "illegal");
        idle_cycles(3, 16'h0120, "halt_illegal");
        @(negedge clk);
        check("illegal flag", 32'(out_illegal), 32'd1);
        check("illegal halted", 32'(out_halted), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst clears illegal", 32'(out_illegal), 32'd0);
        check("rst clears halted", 32'(out_halted), 32'd0);
        model_reset();

        // Flags cleared by reset, then HALT opcode
        @(posedge clk); #1;
        rst = 1'b0;
        push(in_ir, '0, "idle2");
        exec_instr(16'h9033, 4'b0010, "jc_after_rst");
        exec_instr(16'hF800, 4'h0, "halt");
        idle_cycles(2, 16'h4312, "halted");
        @(negedge clk);
        check("halt opcode halted", 32'(out_halted), 32'd1);
        check("halt opcode not illegal", 32'(out_illegal), 32'd0);
        #2 rst = 1'b1;
        model_reset();

        // Reset in the middle of a STORE memory cycle
        @(posedge clk); #1;
        rst = 1'b0;
        push(in_ir, '0, "idle3");
        exec_instr(16'h4B12, 4'h0, "store_rst");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid-MEM rst wr_enable", 32'(out_data_memory_wr_enable), 32'd0);
        check("mid-MEM rst reg_read_en", 32'(out_reg_read_en), 32'd0);
        model_reset();
        in_run = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        push(in_ir, '0, "idle4");
        idle_cycles(4, 16'h4312, "stay_idle");

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
